// File: rtl/pwm_fade_ctrl.sv
// pwm_fade_ctrl: drives the PWM duty_cycle through a repeating rise/hold/fall/hold
// "breathing" pattern, with a graceful fade-out to zero on stop.
module pwm_fade_ctrl #(
    parameter int STEP_TICKS = 500000,
    parameter int HOLD_STEPS = 50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic [6:0] max_level,
    output logic [6:0] duty_cycle,
    output logic       busy,
    output logic       cycle_done
);
    localparam int TW = $clog2(STEP_TICKS);
    localparam int HW = $clog2(HOLD_STEPS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(STEP_TICKS - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_STEPS);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RISE    = 3'd1;
    localparam logic [2:0] S_HOLD_HI = 3'd2;
    localparam logic [2:0] S_FALL    = 3'd3;
    localparam logic [2:0] S_HOLD_LO = 3'd4;

    function automatic logic [6:0] clamp_level(input logic [6:0] lvl);
        logic [6:0] res;
        if (lvl > 7'd100) begin
            res = 7'd100;
        end else begin
            res = lvl;
        end
        return res;
    endfunction

    logic [2:0]    state_r, state_s;
    logic [6:0]    duty_r, duty_s;
    logic [6:0]    peak_r, peak_s;
    logic [6:0]    level_s, inc_s, dec_s;
    logic [HW-1:0] hold_r, hold_s, hold_inc_s;
    logic [TW-1:0] timer_r, timer_s;
    logic          stopping_r, stopping_s;
    logic          busy_r, done_r, done_s;
    logic          tick_s;

    assign tick_s     = (timer_r == TICK_LAST);
    assign level_s    = clamp_level(max_level);
    assign inc_s      = duty_r + 7'd1;
    // A stop from RISE before the first step leaves FALL at 0; never wrap below it.
    assign dec_s      = (duty_r == 7'd0) ? 7'd0 : (duty_r - 7'd1);
    assign hold_inc_s = hold_r + HW'(1);

    // Step timer: parked at 0 while idle, free-running otherwise.
    always_comb begin
        if ((state_r == S_IDLE) || (state_s == S_IDLE) || tick_s) begin
            timer_s = '0;
        end else begin
            timer_s = timer_r + TW'(1);
        end
    end

    // Sequencer next-state and datapath.
    always_comb begin
        state_s    = state_r;
        duty_s     = duty_r;
        peak_s     = peak_r;
        hold_s     = hold_r;
        stopping_s = stopping_r;
        done_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                stopping_s = 1'b0;
                if (start && !stop && (level_s != 7'd0)) begin
                    state_s = S_RISE;
                    peak_s  = level_s;
                    duty_s  = 7'd0;
                    hold_s  = '0;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_RISE: begin
                if (stop) begin
                    stopping_s = 1'b1;
                    state_s    = S_FALL;
                end else if (tick_s) begin
                    duty_s = inc_s;
                    if (inc_s == peak_r) begin
                        state_s = S_HOLD_HI;
                        hold_s  = '0;
                    end else begin
                        state_s = S_RISE;
                    end
                end else begin
                    state_s = S_RISE;
                end
            end
            S_HOLD_HI: begin
                if (stop) begin
                    stopping_s = 1'b1;
                    state_s    = S_FALL;
                end else if (tick_s) begin
                    hold_s = hold_inc_s;
                    if (hold_inc_s == HOLD_LAST) begin
                        state_s = S_FALL;
                    end else begin
                        state_s = S_HOLD_HI;
                    end
                end else begin
                    state_s = S_HOLD_HI;
                end
            end
            S_FALL: begin
                stopping_s = stopping_r | stop;
                if (tick_s) begin
                    duty_s = dec_s;
                    if (dec_s != 7'd0) begin
                        state_s = S_FALL;
                    end else if (stopping_s) begin
                        state_s    = S_IDLE;
                        stopping_s = 1'b0;
                    end else begin
                        state_s = S_HOLD_LO;
                        hold_s  = '0;
                    end
                end else begin
                    state_s = S_FALL;
                end
            end
            S_HOLD_LO: begin
                if (stop) begin
                    state_s    = S_IDLE;
                    stopping_s = 1'b0;
                end else if (tick_s) begin
                    hold_s = hold_inc_s;
                    if (hold_inc_s == HOLD_LAST) begin
                        done_s  = 1'b1;
                        state_s = S_RISE;
                    end else begin
                        state_s = S_HOLD_LO;
                    end
                end else begin
                    state_s = S_HOLD_LO;
                end
            end
            default: begin
                state_s    = S_IDLE;
                duty_s     = 7'd0;
                peak_s     = 7'd0;
                hold_s     = '0;
                stopping_s = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            duty_r     <= 7'd0;
            peak_r     <= 7'd0;
            hold_r     <= '0;
            timer_r    <= '0;
            stopping_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            duty_r     <= duty_s;
            peak_r     <= peak_s;
            hold_r     <= hold_s;
            timer_r    <= timer_s;
            stopping_r <= stopping_s;
            busy_r     <= (state_s != S_IDLE);
            done_r     <= done_s;
        end
    end

    assign duty_cycle = duty_r;
    assign busy       = busy_r;
    assign cycle_done = done_r;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Self-checking bench for pwm_fade_ctrl: directed vector table, corner sequences,
// and randomized commands against a tick-counting behavioural model.
module tb_pwm_fade_ctrl;
    localparam int STEP = 4;
    localparam int HOLD = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic [6:0] max_level;
    logic [6:0] duty_cycle;
    logic       busy;
    logic       cycle_done;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_cnt = -1;
    bit done_seen = 1'b0;

    pwm_fade_ctrl #(.STEP_TICKS(STEP), .HOLD_STEPS(HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .max_level(max_level), .duty_cycle(duty_cycle),
        .busy(busy), .cycle_done(cycle_done)
    );

    always #5 clk = ~clk;

    // Behavioural model: fade position advances once every STEP cycles after start.
    typedef enum {P_IDLE, P_UP, P_TOP, P_DOWN, P_BOTTOM} phase_e;
    typedef struct {
        phase_e phase;
        int     age;
        int     level;
        int     peak;
        int     holds;
        bit     stopping;
        bit     done;
    } mstate_t;
    mstate_t m;

    function automatic mstate_t model_reset();
        mstate_t r;
        r.phase = P_IDLE; r.age = 0; r.level = 0; r.peak = 0;
        r.holds = 0; r.stopping = 1'b0; r.done = 1'b0;
        return r;
    endfunction

    function automatic mstate_t model_next(mstate_t s, logic st, logic sp, logic [6:0] ml);
        mstate_t n;
        int lim;
        bit tick;
        n = s;
        n.done = 1'b0;
        lim = (int'(ml) > 100) ? 100 : int'(ml);
        if (s.phase == P_IDLE) begin
            if (st && !sp && lim > 0) begin
                n.phase = P_UP; n.peak = lim; n.level = 0; n.age = 0; n.holds = 0;
            end
            n.stopping = 1'b0;
            return n;
        end
        tick  = ((s.age % STEP) == STEP - 1);
        n.age = s.age + 1;
        case (s.phase)
            P_UP: begin
                if (sp) begin
                    n.stopping = 1'b1; n.phase = P_DOWN;
                end else if (tick) begin
                    n.level = s.level + 1;
                    if (n.level == s.peak) begin n.phase = P_TOP; n.holds = 0; end
                end
            end
            P_TOP: begin
                if (sp) begin
                    n.stopping = 1'b1; n.phase = P_DOWN;
                end else if (tick) begin
                    n.holds = s.holds + 1;
                    if (n.holds == HOLD) n.phase = P_DOWN;
                end
            end
            P_DOWN: begin
                if (sp) n.stopping = 1'b1;
                if (tick) begin
                    if (s.level > 0) n.level = s.level - 1;
                    if (n.level == 0) begin
                        if (n.stopping) begin n.phase = P_IDLE; n.stopping = 1'b0; end
                        else begin n.phase = P_BOTTOM; n.holds = 0; end
                    end
                end
            end
            P_BOTTOM: begin
                if (sp) begin
                    n.phase = P_IDLE; n.stopping = 1'b0;
                end else if (tick) begin
                    n.holds = s.holds + 1;
                    if (n.holds == HOLD) begin n.done = 1'b1; n.phase = P_UP; end
                end
            end
            default: n = model_reset();
        endcase
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= model_reset();
        else        m <= model_next(m, start, stop, max_level);
    end

    always @(negedge clk) begin
        if (cycle_done === 1'b1) done_seen <= 1'b1;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d (edge %0d)", nm, act, exp, edge_cnt);
        end
    endtask

    task automatic clk_edge(input logic st, input logic sp, input logic [6:0] lvl);
        start = st; stop = sp; max_level = lvl;
        @(posedge clk);
        #1;
        start = 1'b0; stop = 1'b0;
        edge_cnt++;
    endtask

    task automatic run_to(input int n, input logic [6:0] lvl);
        while (edge_cnt < n) clk_edge(1'b0, 1'b0, lvl);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; stop = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        edge_cnt = -1;
    endtask

    typedef struct {
        int         edge_no;
        logic       st;
        logic       sp;
        logic [6:0] lvl;
        logic [6:0] duty;
        logic       bsy;
        logic       dn;
    } vec_t;
    vec_t tbl[$];

    initial begin
        logic st, sp;
        logic [6:0] lvl;
        int max_seen;

        // Full breathing cycle with max_level=3; a start while busy (edge 5) is ignored.
        tbl.push_back('{0,  1'b1, 1'b0, 7'd3,  7'd0, 1'b1, 1'b0});
        tbl.push_back('{3,  1'b0, 1'b0, 7'd3,  7'd0, 1'b1, 1'b0});
        tbl.push_back('{4,  1'b0, 1'b0, 7'd3,  7'd1, 1'b1, 1'b0});
        tbl.push_back('{5,  1'b1, 1'b0, 7'd50, 7'd1, 1'b1, 1'b0});
        tbl.push_back('{8,  1'b0, 1'b0, 7'd50, 7'd2, 1'b1, 1'b0});
        tbl.push_back('{11, 1'b0, 1'b0, 7'd50, 7'd2, 1'b1, 1'b0});
        tbl.push_back('{12, 1'b0, 1'b0, 7'd50, 7'd3, 1'b1, 1'b0});
        tbl.push_back('{20, 1'b0, 1'b0, 7'd50, 7'd3, 1'b1, 1'b0});
        tbl.push_back('{23, 1'b0, 1'b0, 7'd50, 7'd3, 1'b1, 1'b0});
        tbl.push_back('{24, 1'b0, 1'b0, 7'd50, 7'd2, 1'b1, 1'b0});
        tbl.push_back('{28, 1'b0, 1'b0, 7'd50, 7'd1, 1'b1, 1'b0});
        tbl.push_back('{32, 1'b0, 1'b0, 7'd50, 7'd0, 1'b1, 1'b0});
        tbl.push_back('{39, 1'b0, 1'b0, 7'd50, 7'd0, 1'b1, 1'b0});
        tbl.push_back('{40, 1'b0, 1'b0, 7'd50, 7'd0, 1'b1, 1'b1});
        tbl.push_back('{41, 1'b0, 1'b0, 7'd50, 7'd0, 1'b1, 1'b0});
        tbl.push_back('{44, 1'b0, 1'b0, 7'd50, 7'd1, 1'b1, 1'b0});

        rst_n = 1'b0; start = 1'b0; stop = 1'b0; max_level = 7'd0;
        #12;
        check("reset.duty", duty_cycle, 7'd0);
        check("reset.busy", busy, 1'b0);
        check("reset.done", cycle_done, 1'b0);
        do_reset();

        foreach (tbl[i]) begin
            run_to(tbl[i].edge_no - 1, tbl[i].lvl);
            clk_edge(tbl[i].st, tbl[i].sp, tbl[i].lvl);
            check($sformatf("tbl_e%0d.duty", tbl[i].edge_no), duty_cycle, tbl[i].duty);
            check($sformatf("tbl_e%0d.busy", tbl[i].edge_no), busy, tbl[i].bsy);
            check($sformatf("tbl_e%0d.done", tbl[i].edge_no), cycle_done, tbl[i].dn);
        end

        // Clamp: 120 saturates at 100 at edge 400, holds, then falls at 412.
        do_reset();
        max_seen = 0;
        clk_edge(1'b1, 1'b0, 7'd120);
        while (edge_cnt < 412) begin
            clk_edge(1'b0, 1'b0, 7'd120);
            if (int'(duty_cycle) > max_seen) max_seen = int'(duty_cycle);
            if (edge_cnt == 399) check("clamp.e399", duty_cycle, 7'd99);
            if (edge_cnt == 400) check("clamp.e400", duty_cycle, 7'd100);
            if (edge_cnt == 411) check("clamp.hold", duty_cycle, 7'd100);
        end
        check("clamp.e412", duty_cycle, 7'd99);
        check("clamp.max", max_seen, 100);

        // Stop during rise at edge 9.
        do_reset();
        done_seen = 1'b0;
        clk_edge(1'b1, 1'b0, 7'd10);
        run_to(8, 7'd10);
        check("stoprise.e8", duty_cycle, 7'd2);
        clk_edge(1'b0, 1'b1, 7'd10);
        check("stoprise.e9busy", busy, 1'b1);
        run_to(12, 7'd10);
        check("stoprise.e12", duty_cycle, 7'd1);
        run_to(15, 7'd10);
        check("stoprise.e15busy", busy, 1'b1);
        run_to(16, 7'd10);
        check("stoprise.e16duty", duty_cycle, 7'd0);
        check("stoprise.e16busy", busy, 1'b0);
        run_to(30, 7'd10);
        check("stoprise.idle", busy, 1'b0);
        check("stoprise.nodone", done_seen, 1'b0);

        // Ignored commands in IDLE.
        do_reset();
        clk_edge(1'b1, 1'b0, 7'd0);
        check("ign.zero", busy, 1'b0);
        clk_edge(1'b1, 1'b1, 7'd5);
        check("ign.both", busy, 1'b0);
        run_to(8, 7'd5);
        check("ign.busy", busy, 1'b0);
        check("ign.duty", duty_cycle, 7'd0);

        // Stop in HOLD_LO at edge 34.
        do_reset();
        clk_edge(1'b1, 1'b0, 7'd3);
        run_to(33, 7'd3);
        check("stoplo.e33busy", busy, 1'b1);
        done_seen = 1'b0;
        clk_edge(1'b0, 1'b1, 7'd3);
        check("stoplo.e34busy", busy, 1'b0);
        check("stoplo.e34duty", duty_cycle, 7'd0);
        run_to(46, 7'd3);
        check("stoplo.idle", busy, 1'b0);
        check("stoplo.nodone", done_seen, 1'b0);

        // Asynchronous reset mid-fade.
        do_reset();
        clk_edge(1'b1, 1'b0, 7'd3);
        run_to(10, 7'd3);
        check("areset.pre", duty_cycle, 7'd2);
        rst_n = 1'b0;
        #2;
        check("areset.duty", duty_cycle, 7'd0);
        check("areset.busy", busy, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (30) clk_edge(1'b0, 1'b0, 7'd3);
        check("areset.idle", busy, 1'b0);
        check("areset.idleduty", duty_cycle, 7'd0);

        // Randomized commands against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            st  = ($urandom_range(0, 19) == 0);
            sp  = ($urandom_range(0, 59) == 0);
            lvl = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 9));
            clk_edge(st, sp, lvl);
            check("rnd.duty", duty_cycle, m.level);
            check("rnd.busy", busy, (m.phase != P_IDLE));
            check("rnd.done", cycle_done, m.done);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
